// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the Datapath: instruction/handshake inputs
// toward the sequencer, control strobes and status back out.
interface control_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             stop;
   logic [31:0]      IR;
   logic             mem_ready;

   logic             PCout, PCin, IncPC, MARin;
   logic             MDRin, MDRout, MDMuxread, mem_read;
   logic             IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
   logic [15:0]      reg_in;
   logic [15:0]      reg_out;
   logic             Cout;
   logic [31:0]      C_ext;
   logic [4:0]       alu_op;
   logic             alu_en;
   logic             running;
   logic             halted;
   logic             mem_err;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  start, stop, IR, mem_ready,
      output PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, mem_read,
             IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
             reg_in, reg_out, Cout, C_ext, alu_op, alu_en,
             running, halted, mem_err, instr_count
   );

   modport slave (
      output start, stop, IR, mem_ready,
      input  PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, mem_read,
             IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
             reg_in, reg_out, Cout, C_ext, alu_op, alu_en,
             running, halted, mem_err, instr_count
   );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2) then opcode-dependent execute (T3-T6),
// driving the Datapath strobes for one instruction at a time.
module control_sequencer #(
   parameter int CNT_W    = 16,
   parameter int WAIT_MAX = 15
) (
   input logic                 clock,
   input logic                 clear,
   control_sequencer_if.master bus
);
   localparam int WAIT_W = $clog2(WAIT_MAX + 1);

   typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

   state_t            state;
   state_t            last_state;
   logic [CNT_W-1:0]  count;
   logic [WAIT_W-1:0] wait_cnt;
   logic              err;
   logic [4:0]        opcode;
   logic [3:0]        ra, rb, rc;
   logic              is_rtype, is_imm, is_muldiv, is_halt;

   assign opcode = bus.IR[31:27];
   assign ra     = bus.IR[26:23];
   assign rb     = bus.IR[22:19];
   assign rc     = bus.IR[18:15];

   assign is_rtype  = opcode inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01001, 5'b01011};
   assign is_imm    = opcode inside {5'b01100, 5'b01101, 5'b01110};
   assign is_muldiv = opcode inside {5'b01111, 5'b10000};
   assign is_halt   = (opcode == 5'b11011);

   // nop and unlisted opcodes retire straight out of T3
   assign last_state = is_muldiv ? T6 : ((is_rtype || is_imm) ? T5 : T3);

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state    <= IDLE;
         count    <= '0;
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) state <= T0;
            T0: begin
               state    <= T1;
               wait_cnt <= '0;
            end
            T1: begin
               if (bus.mem_ready) begin
                  state <= T2;
               end else if (wait_cnt == WAIT_W'(WAIT_MAX - 1)) begin
                  state <= HALT;
                  err   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            T2: state <= T3;
            T3, T4, T5, T6: begin
               if (state == T3 && is_halt) begin
                  state <= HALT;
               end else if (state == last_state) begin
                  state <= bus.stop ? IDLE : T0;
                  count <= count + 1'b1;
               end else begin
                  state <= state_t'(state + 4'd1);
               end
            end
            default: state <= HALT;
         endcase
      end
   end

   always_comb begin
      bus.PCout     = 1'b0;
      bus.PCin      = 1'b0;
      bus.IncPC     = 1'b0;
      bus.MARin     = 1'b0;
      bus.MDRin     = 1'b0;
      bus.MDRout    = 1'b0;
      bus.MDMuxread = 1'b0;
      bus.mem_read  = 1'b0;
      bus.IRin      = 1'b0;
      bus.Yin       = 1'b0;
      bus.Zlowin    = 1'b0;
      bus.Zhighin   = 1'b0;
      bus.Zlowout   = 1'b0;
      bus.Zhighout  = 1'b0;
      bus.HIin      = 1'b0;
      bus.LOin      = 1'b0;
      bus.Cout      = 1'b0;
      bus.alu_en    = 1'b0;
      bus.reg_in    = '0;
      bus.reg_out   = '0;
      case (state)
         T0: begin
            bus.PCout  = 1'b1;
            bus.MARin  = 1'b1;
            bus.IncPC  = 1'b1;
            bus.Zlowin = 1'b1;
         end
         T1: begin
            bus.Zlowout   = 1'b1;
            bus.PCin      = 1'b1;
            bus.mem_read  = 1'b1;
            bus.MDMuxread = 1'b1;
            bus.MDRin     = 1'b1;
         end
         T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         T3: begin
            if (is_rtype || is_imm) begin
               bus.reg_out = 16'h0001 << rb;
               bus.Yin     = 1'b1;
            end else if (is_muldiv) begin
               bus.reg_out = 16'h0001 << ra;
               bus.Yin     = 1'b1;
            end
         end
         T4: begin
            if (is_rtype) begin
               bus.reg_out = 16'h0001 << rc;
               bus.alu_en  = 1'b1;
               bus.Zlowin  = 1'b1;
            end else if (is_imm) begin
               bus.Cout   = 1'b1;
               bus.alu_en = 1'b1;
               bus.Zlowin = 1'b1;
            end else if (is_muldiv) begin
               bus.reg_out = 16'h0001 << rb;
               bus.alu_en  = 1'b1;
               bus.Zlowin  = 1'b1;
               bus.Zhighin = 1'b1;
            end
         end
         T5: begin
            if (is_rtype || is_imm) begin
               bus.Zlowout = 1'b1;
               bus.reg_in  = 16'h0001 << ra;
            end else if (is_muldiv) begin
               bus.Zlowout = 1'b1;
               bus.LOin    = 1'b1;
            end
         end
         T6: begin
            if (is_muldiv) begin
               bus.Zhighout = 1'b1;
               bus.HIin     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.alu_op      = opcode;
   assign bus.C_ext       = {{13{bus.IR[18]}}, bus.IR[18:0]};
   assign bus.running     = (state inside {T0, T1, T2, T3, T4, T5, T6});
   assign bus.halted      = (state == HALT);
   assign bus.mem_err     = err;
   assign bus.instr_count = count;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed plus randomized bench for control_sequencer, checked cycle-by-cycle against
// an instruction-level model of the expected strobe sequence.
module tb_control_sequencer;
   localparam int CNT_W    = 16;
   localparam int WAIT_MAX = 15;

   typedef logic [17:0] strobe_t;
   localparam strobe_t S_PCOUT     = 18'h20000;
   localparam strobe_t S_PCIN      = 18'h10000;
   localparam strobe_t S_INCPC     = 18'h08000;
   localparam strobe_t S_MARIN     = 18'h04000;
   localparam strobe_t S_MDRIN     = 18'h02000;
   localparam strobe_t S_MDROUT    = 18'h01000;
   localparam strobe_t S_MDMUXREAD = 18'h00800;
   localparam strobe_t S_MEMREAD   = 18'h00400;
   localparam strobe_t S_IRIN      = 18'h00200;
   localparam strobe_t S_YIN       = 18'h00100;
   localparam strobe_t S_ZLOWIN    = 18'h00080;
   localparam strobe_t S_ZHIGHIN   = 18'h00040;
   localparam strobe_t S_ZLOWOUT   = 18'h00020;
   localparam strobe_t S_ZHIGHOUT  = 18'h00010;
   localparam strobe_t S_HIIN      = 18'h00008;
   localparam strobe_t S_LOIN      = 18'h00004;
   localparam strobe_t S_COUT      = 18'h00002;
   localparam strobe_t S_ALUEN     = 18'h00001;

   localparam strobe_t F_T0 = S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN;
   localparam strobe_t F_T1 = S_ZLOWOUT | S_PCIN | S_MEMREAD | S_MDMUXREAD | S_MDRIN;
   localparam strobe_t F_T2 = S_MDROUT | S_IRIN;

   typedef struct packed {
      strobe_t     s;
      logic [15:0] ri;
      logic [15:0] ro;
   } exp_t;

   logic clock = 1'b0;
   logic clear;
   always #5 clock = ~clock;

   control_sequencer_if #(.CNT_W(CNT_W)) bus();

   control_sequencer #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
      .clock(clock),
      .clear(clear),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;
   logic [CNT_W-1:0] expCount;

   function automatic exp_t mk(input strobe_t s, input logic [15:0] ri, input logic [15:0] ro);
      exp_t e;
      e.s  = s;
      e.ri = ri;
      e.ro = ro;
      return e;
   endfunction

   function automatic strobe_t observedStrobes();
      return {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.MDMuxread,
              bus.mem_read, bus.IRin, bus.Yin, bus.Zlowin, bus.Zhighin, bus.Zlowout, bus.Zhighout,
              bus.HIin, bus.LOin, bus.Cout, bus.alu_en};
   endfunction

   function automatic int execLen(input int op);
      if (op inside {3, 4, 5, 6, 9, 11, 12, 13, 14}) return 3;
      if (op inside {15, 16}) return 4;
      return 1;
   endfunction

   // Expected strobes for execute step k (0 = T3) of instruction ir
   function automatic exp_t expExec(input logic [31:0] ir, input int k);
      int op, ra, rb, rc;
      exp_t e;
      e  = '0;
      op = int'(ir >> 27);
      ra = int'((ir >> 23) & 32'hF);
      rb = int'((ir >> 19) & 32'hF);
      rc = int'((ir >> 15) & 32'hF);
      if (op inside {3, 4, 5, 6, 9, 11}) begin
         case (k)
            0: e = mk(S_YIN, 16'h0, 16'(1) << rb);
            1: e = mk(S_ALUEN | S_ZLOWIN, 16'h0, 16'(1) << rc);
            2: e = mk(S_ZLOWOUT, 16'(1) << ra, 16'h0);
            default: ;
         endcase
      end else if (op inside {12, 13, 14}) begin
         case (k)
            0: e = mk(S_YIN, 16'h0, 16'(1) << rb);
            1: e = mk(S_COUT | S_ALUEN | S_ZLOWIN, 16'h0, 16'h0);
            2: e = mk(S_ZLOWOUT, 16'(1) << ra, 16'h0);
            default: ;
         endcase
      end else if (op inside {15, 16}) begin
         case (k)
            0: e = mk(S_YIN, 16'h0, 16'(1) << ra);
            1: e = mk(S_ALUEN | S_ZLOWIN | S_ZHIGHIN, 16'h0, 16'(1) << rb);
            2: e = mk(S_ZLOWOUT | S_LOIN, 16'h0, 16'h0);
            3: e = mk(S_ZHIGHOUT | S_HIIN, 16'h0, 16'h0);
            default: ;
         endcase
      end
      return e;
   endfunction

   function automatic logic [31:0] expCext(input logic [31:0] ir);
      logic [31:0] c;
      c = ir & 32'h0007FFFF;
      if (c >= 32'h00040000) c = c - 32'h00080000;
      return c;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkCycle(input string tag, input exp_t e, input logic [2:0] status);
      int drivers;
      drivers = int'(bus.reg_out != 16'h0) + int'(bus.PCout) + int'(bus.MDRout) +
                int'(bus.Zlowout) + int'(bus.Zhighout) + int'(bus.Cout);
      checkOutput({tag, "/strobes"}, 64'(observedStrobes()), 64'(e.s));
      checkOutput({tag, "/reg_in"}, 64'(bus.reg_in), 64'(e.ri));
      checkOutput({tag, "/reg_out"}, 64'(bus.reg_out), 64'(e.ro));
      checkOutput({tag, "/status"}, 64'({bus.running, bus.halted, bus.mem_err}), 64'(status));
      checkOutput({tag, "/count"}, 64'(bus.instr_count), 64'(expCount));
      checkOutput({tag, "/bus_drivers_le1"}, 64'(drivers <= 1), 64'(1));
   endtask

   task automatic applyStimulus(input logic s, input logic st, input logic mr);
      bus.start     = s;
      bus.stop      = st;
      bus.mem_ready = mr;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic coin(input logic noise);
      return noise && ($urandom_range(0, 1) == 1);
   endfunction

   // Starts in T0; runs one non-halt instruction through retire
   task automatic runInstr(input logic [31:0] ir, input int nwait, input logic stopAtEnd, input logic noise);
      int n;
      bus.IR = ir;
      checkCycle("T0", mk(F_T0, 16'h0, 16'h0), 3'b100);
      applyStimulus(coin(noise), coin(noise), 1'b0);
      step();
      for (int w = 0; w < nwait; w++) begin
         checkCycle("T1wait", mk(F_T1, 16'h0, 16'h0), 3'b100);
         applyStimulus(coin(noise), coin(noise), 1'b0);
         step();
      end
      checkCycle("T1", mk(F_T1, 16'h0, 16'h0), 3'b100);
      applyStimulus(coin(noise), coin(noise), 1'b1);
      step();
      checkCycle("T2", mk(F_T2, 16'h0, 16'h0), 3'b100);
      applyStimulus(coin(noise), coin(noise), 1'b0);
      step();
      n = execLen(int'(ir >> 27));
      for (int k = 0; k < n; k++) begin
         checkCycle($sformatf("EX%0d", k), expExec(ir, k), 3'b100);
         if (k == 0) begin
            checkOutput("alu_op", 64'(bus.alu_op), 64'(ir >> 27));
            checkOutput("C_ext", 64'(bus.C_ext), 64'(expCext(ir)));
         end
         if (k == n - 1) applyStimulus(coin(noise), stopAtEnd, 1'b0);
         else            applyStimulus(coin(noise), coin(noise), 1'b0);
         step();
      end
      expCount = expCount + 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired before end of test");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int ops[13] = '{3, 4, 5, 6, 9, 11, 12, 13, 14, 15, 16, 26, 7};
      logic [31:0] rnd;
      logic [31:0] ir;
      logic [31:0] addIr;
      addIr    = 32'h18918000;
      expCount = '0;
      bus.IR   = 32'h0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      clear = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      clear = 1'b0;
      checkCycle("reset", '0, 3'b000);
      step();
      checkCycle("idle_hold", '0, 3'b000);

      applyStimulus(1'b1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0);
      runInstr(32'h28918000, 0, 1'b0, 1'b0);
      checkOutput("count_after_and", 64'(bus.instr_count), 64'(1));
      runInstr(32'h6117FFFF, 0, 1'b0, 1'b0);
      runInstr({5'b01111, 4'd4, 4'd5, 19'd0}, 2, 1'b0, 1'b0);
      runInstr(32'h18918000, WAIT_MAX - 1, 1'b0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         rnd = $urandom;
         ir  = {5'(ops[$urandom_range(0, 12)]), rnd[26:0]};
         runInstr(ir, int'($urandom_range(0, 4)), 1'b0, 1'b1);
      end

      runInstr(addIr, 1, 1'b1, 1'b0);
      checkCycle("idle_after_stop", '0, 3'b000);
      step();
      checkCycle("idle_after_stop_hold", '0, 3'b000);

      applyStimulus(1'b1, 1'b0, 1'b0);
      step();
      bus.IR = addIr;
      applyStimulus(1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0);
      step();
      step();
      checkCycle("pre_clear_T4", expExec(addIr, 1), 3'b100);
      #2 clear = 1'b1;
      expCount = '0;
      #2 checkCycle("clear_async", '0, 3'b000);
      #2 clear = 1'b0;
      step();
      checkCycle("post_clear", '0, 3'b000);

      applyStimulus(1'b1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0);
      runInstr({5'd26, 27'h1234567}, 0, 1'b0, 1'b0);
      bus.IR = {5'd27, 27'h0};
      checkCycle("halt_T0", mk(F_T0, 16'h0, 16'h0), 3'b100);
      step();
      applyStimulus(1'b0, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkCycle("halt_T2", mk(F_T2, 16'h0, 16'h0), 3'b100);
      step();
      checkCycle("halt_T3", '0, 3'b100);
      step();
      checkCycle("halted", '0, 3'b010);
      applyStimulus(1'b1, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkCycle("halted_ignores_start", '0, 3'b010);

      clear = 1'b1;
      step();
      clear = 1'b0;
      expCount = '0;
      checkCycle("clear_from_halt", '0, 3'b000);

      applyStimulus(1'b1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0);
      runInstr({5'd26, 27'h0}, 0, 1'b0, 1'b0);
      checkCycle("timeout_T0", mk(F_T0, 16'h0, 16'h0), 3'b100);
      step();
      for (int w = 0; w < WAIT_MAX; w++) begin
         checkCycle("timeout_T1", mk(F_T1, 16'h0, 16'h0), 3'b100);
         step();
      end
      checkCycle("timeout_halt", '0, 3'b011);
      step();
      checkCycle("timeout_sticky", '0, 3'b011);
      clear = 1'b1;
      step();
      clear = 1'b0;
      expCount = '0;
      checkCycle("clear_mem_err", '0, 3'b000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
